// File: rtl/ex_muldiv_iter_if.sv
// Request/response bundle between the EX stage and the iterative multiply/divide unit.
// The EX stage is the master; ex_muldiv_iter is the slave.
interface ex_muldiv_iter_if #(
   parameter int DATA_W = 32
);
   logic                  start_i;
   logic [1:0]            op_i;
   logic [DATA_W-1:0]     opdata1_i;
   logic [DATA_W-1:0]     opdata2_i;
   logic                  annul_i;
   logic [2*DATA_W-1:0]   result_o;
   logic                  ready_o;
   logic                  busy_o;
   logic                  div0_o;

   modport master (
      output start_i, op_i, opdata1_i, opdata2_i, annul_i,
      input  result_o, ready_o, busy_o, div0_o
   );

   modport slave (
      input  start_i, op_i, opdata1_i, opdata2_i, annul_i,
      output result_o, ready_o, busy_o, div0_o
   );
endinterface

// File: rtl/ex_muldiv_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit beside the EX-stage ALU; one bit per RUN cycle.
// Define MULDIV_EARLY_OUT_EN to let multiplies finish once the remaining multiplier bits are zero.
module ex_muldiv_iter #(
   parameter int DATA_W = 32
) (
   input  logic            clk,
   input  logic            rst,
   ex_muldiv_iter_if.slave bus
);
   localparam int CNT_W = $clog2(DATA_W) + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DIVZERO,
      S_RUN,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q;
   logic                  is_div_q;
   logic                  neg_res_q;
   logic                  neg_rem_q;
   logic [2*DATA_W-1:0]   acc_q;
   logic [2*DATA_W-1:0]   mcand_q;
   logic [DATA_W-1:0]     b_q;
   logic [2*DATA_W-1:0]   result_q;
   logic                  div0_q;

   logic                  signed_op, a_neg, b_neg;
   logic [DATA_W-1:0]     a_mag, b_mag;
   logic                  accept, div0_req, run_last;

   logic [2*DATA_W-1:0]   acc_step, mcand_step, result_fix;
   logic [DATA_W-1:0]     b_step, sub, quo, rem;
   logic [DATA_W:0]       sh;
   logic                  ge;

   // Signed ops work on magnitudes; the most negative value maps onto itself as unsigned.
   assign signed_op = ~bus.op_i[0];
   assign a_neg     = signed_op & bus.opdata1_i[DATA_W-1];
   assign b_neg     = signed_op & bus.opdata2_i[DATA_W-1];
   assign a_mag     = a_neg ? -bus.opdata1_i : bus.opdata1_i;
   assign b_mag     = b_neg ? -bus.opdata2_i : bus.opdata2_i;

   assign accept    = (state_q == S_IDLE) && bus.start_i && !bus.annul_i;
   assign div0_req  = bus.op_i[1] && (bus.opdata2_i == '0);

`ifdef MULDIV_EARLY_OUT_EN
   assign run_last  = (cnt_q == CNT_W'(DATA_W - 1)) ||
                      (!is_div_q && (b_q[DATA_W-1:1] == '0));
`else
   assign run_last  = (cnt_q == CNT_W'(DATA_W - 1));
`endif

   // One iteration: shift-add multiply (LSB first) or restoring divide (MSB first).
   // For divide, acc_q holds {remainder, remaining dividend/quotient bits}.
   always_comb begin
      acc_step   = acc_q;
      mcand_step = mcand_q;
      b_step     = b_q;
      sh         = acc_q[2*DATA_W-1:DATA_W-1];
      ge         = (sh >= {1'b0, b_q});
      sub        = sh[DATA_W-1:0] - b_q;
      if (is_div_q) begin
         if (ge) acc_step = {sub, acc_q[DATA_W-2:0], 1'b1};
         else    acc_step = {acc_q[2*DATA_W-2:0], 1'b0};
      end else begin
         if (b_q[0]) acc_step = acc_q + mcand_q;
         mcand_step = mcand_q << 1;
         b_step     = b_q >> 1;
      end
   end

   always_comb begin
      quo = acc_step[DATA_W-1:0];
      rem = acc_step[2*DATA_W-1:DATA_W];
      if (is_div_q) result_fix = {neg_rem_q ? -rem : rem, neg_res_q ? -quo : quo};
      else          result_fix = neg_res_q ? -acc_step : acc_step;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (accept) state_d = div0_req ? S_DIVZERO : S_RUN;
         S_DIVZERO: state_d = bus.annul_i ? S_IDLE : S_DONE;
         S_RUN: begin
            if (bus.annul_i)   state_d = S_IDLE;
            else if (run_last) state_d = S_DONE;
         end
         S_DONE:    if (bus.annul_i || !bus.start_i) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         acc_q     <= '0;
         mcand_q   <= '0;
         b_q       <= '0;
         result_q  <= '0;
         div0_q    <= 1'b0;
      end else begin
         div0_q <= 1'b0;
         case (state_q)
            S_IDLE: if (accept) begin
               is_div_q  <= bus.op_i[1];
               neg_res_q <= a_neg ^ b_neg;
               neg_rem_q <= a_neg;
               cnt_q     <= '0;
               mcand_q   <= {{DATA_W{1'b0}}, a_mag};
               b_q       <= b_mag;
               acc_q     <= bus.op_i[1] ? {{DATA_W{1'b0}}, a_mag} : '0;
            end
            S_DIVZERO: if (!bus.annul_i) begin
               result_q <= '0;
               div0_q   <= 1'b1;
            end
            S_RUN: if (!bus.annul_i) begin
               acc_q   <= acc_step;
               mcand_q <= mcand_step;
               b_q     <= b_step;
               cnt_q   <= cnt_q + CNT_W'(1);
               if (run_last) result_q <= result_fix;
            end
            default: ;
         endcase
      end
   end

   assign bus.result_o = result_q;
   assign bus.ready_o  = (state_q == S_DONE);
   assign bus.busy_o   = (state_q == S_RUN) || (state_q == S_DIVZERO);
   assign bus.div0_o   = div0_q;
endmodule

// File: tb/tb_ex_muldiv_iter.sv
// Scoreboard bench for ex_muldiv_iter: directed vectors push expectations, a negedge monitor
// pops and compares on each rising ready_o; latency, handshake, annul and reset checked inline.
module tb_ex_muldiv_iter;
   localparam int W = 32;

   typedef struct {
      logic [2*W-1:0] res;
      logic           div0;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t sb[$];
   logic ready_prev = 1'b0;
   logic [2*W-1:0] last_exp = '0;

   ex_muldiv_iter_if #(.DATA_W(W)) bus ();

   ex_muldiv_iter #(.DATA_W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int exp_lat(input logic [1:0] op, input logic [W-1:0] b);
`ifdef MULDIV_EARLY_OUT_EN
      logic [W-1:0] m;
      int           top;
`endif
      if (op[1]) return (b == '0) ? 2 : W + 1;
`ifdef MULDIV_EARLY_OUT_EN
      m   = (!op[0] && b[W-1]) ? -b : b;
      top = 0;
      for (int i = 0; i < W; i++) if (m[i]) top = i + 1;
      return ((top < 1) ? 1 : top) + 1;
`else
      return W + 1;
`endif
   endfunction

   // Monitor: compare each new result against the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst && bus.ready_o && !ready_prev) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_ready: got result 0x%0h with no request outstanding", bus.result_o);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result", bus.result_o, e.res);
            check("div0_with_ready", {63'd0, bus.div0_o}, {63'd0, e.div0});
         end
      end
      ready_prev = bus.ready_o;
   end

   task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] exp_res, input int hold);
      exp_t e;
      int   lat;
      e.res  = exp_res;
      e.div0 = op[1] && (b == '0);
      sb.push_back(e);
      last_exp = exp_res;
      @(negedge clk);
      bus.start_i   = 1'b1;
      bus.op_i      = op;
      bus.opdata1_i = a;
      bus.opdata2_i = b;
      @(posedge clk); #1;
      lat = 1;
      check("busy_after_accept", {63'd0, bus.busy_o}, 64'd1);
      bus.op_i      = ~op;
      bus.opdata1_i = ~a;
      bus.opdata2_i = ~b;
      while (!bus.ready_o && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check("latency", lat, exp_lat(op, b));
      check("busy_in_done", {63'd0, bus.busy_o}, 64'd0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("ready_held", {63'd0, bus.ready_o}, 64'd1);
         check("div0_pulse_width", {63'd0, bus.div0_o}, 64'd0);
         check("result_held", bus.result_o, exp_res);
      end
      @(negedge clk);
      bus.start_i = 1'b0;
      @(posedge clk); #1;
      check("ready_drop", {63'd0, bus.ready_o}, 64'd0);
   endtask

   initial begin
      bus.start_i   = 1'b0;
      bus.op_i      = 2'b00;
      bus.opdata1_i = '0;
      bus.opdata2_i = '0;
      bus.annul_i   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_result", bus.result_o, 64'd0);
      check("rst_ready", {63'd0, bus.ready_o}, 64'd0);
      check("rst_busy", {63'd0, bus.busy_o}, 64'd0);
      @(negedge clk) rst = 1'b1;

      run_op(2'b01, 32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F, 0);
      run_op(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA, 0);
      run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 0);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 0);
      run_op(2'b11, 32'h0000_1234, 32'h0000_0000, 64'h0, 3);
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0);
      run_op(2'b11, 32'd100,       32'd7,         64'h0000_0002_0000_000E, 3);
      run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0);
      run_op(2'b10, 32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 0);
      run_op(2'b00, 32'd7,         32'd0,         64'h0, 0);
      run_op(2'b10, 32'd5,         32'd0,         64'h0, 0);
      run_op(2'b01, 32'h1234_5678, 32'h0000_0100, 64'h0000_0012_3456_7800, 0);

      // start with annul in the same cycle is not accepted
      @(negedge clk);
      bus.start_i   = 1'b1;
      bus.annul_i   = 1'b1;
      bus.op_i      = 2'b01;
      bus.opdata1_i = 32'd9;
      bus.opdata2_i = 32'd9;
      @(posedge clk); #1;
      check("annul_blocks_start", {63'd0, bus.busy_o}, 64'd0);
      @(negedge clk);
      bus.start_i = 1'b0;
      bus.annul_i = 1'b0;

      // annul during RUN cycle 10
      @(negedge clk);
      bus.start_i   = 1'b1;
      bus.op_i      = 2'b01;
      bus.opdata1_i = 32'd3;
      bus.opdata2_i = 32'hFFFF_0000;
      @(posedge clk);
      repeat (9) @(posedge clk);
      #1;
      check("busy_before_annul", {63'd0, bus.busy_o}, 64'd1);
      @(negedge clk);
      bus.annul_i = 1'b1;
      bus.start_i = 1'b0;
      @(posedge clk); #1;
      check("annul_busy", {63'd0, bus.busy_o}, 64'd0);
      check("annul_ready", {63'd0, bus.ready_o}, 64'd0);
      check("annul_result_kept", bus.result_o, last_exp);
      @(negedge clk) bus.annul_i = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      check("annul_no_ready", {63'd0, bus.ready_o}, 64'd0);
      run_op(2'b01, 32'd3, 32'hFFFF_0000, 64'h0000_0002_FFFD_0000, 0);

      // asynchronous reset during RUN cycle 5
      @(negedge clk);
      bus.start_i   = 1'b1;
      bus.op_i      = 2'b01;
      bus.opdata1_i = 32'd11;
      bus.opdata2_i = 32'hFFFF_FFFF;
      @(posedge clk);
      repeat (4) @(posedge clk);
      #1;
      check("busy_before_rst", {63'd0, bus.busy_o}, 64'd1);
      #2 rst = 1'b0;
      #1;
      check("async_rst_result", bus.result_o, 64'd0);
      check("async_rst_busy", {63'd0, bus.busy_o}, 64'd0);
      check("async_rst_ready", {63'd0, bus.ready_o}, 64'd0);
      @(negedge clk);
      bus.start_i = 1'b0;
      rst         = 1'b1;
      run_op(2'b00, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 64'h0000_0000_0000_000F, 0);

      repeat (2) @(posedge clk);
      check("scoreboard_drained", sb.size(), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, expected finish before 200000 ns");
      $fatal(1, "watchdog expired");
   end
endmodule
